// File: rtl/obi_mem_responder_if.sv
// OBI-style req/gnt/rvalid bus between an initiator (cv32e40p port) and a
// memory responder.
//
// Handshake: the address phase completes in any cycle where req && gnt are
// both high at the rising clock edge; addr/we/be/wdata are sampled on that
// edge. The responder answers every accepted request with exactly one rvalid
// cycle, in acceptance order. There is no ready on the response side: the
// initiator must always accept rvalid.
interface obi_mem_responder_if;
    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/obi_mem_responder.sv
// obi_mem_responder: memory end of an OBI req/gnt/rvalid port.
// Grants up to MAX_PND outstanding transactions, performs byte-enabled writes
// and reads on a word-addressed array, and returns in-order responses no
// earlier than LATENCY cycles after the grant.
// Optional build macro OBI_RESP_STALL_EN adds gnt_stall_i / rsp_stall_i to
// inject arbitrary grant and response delays.
module obi_mem_responder #(
    parameter int MEM_WORDS = 256,
    parameter int MAX_PND   = 2,
    parameter int LATENCY   = 1
) (
    input  logic               clock,
    input  logic               reset,
`ifdef OBI_RESP_STALL_EN
    input  logic               gnt_stall_i,
    input  logic               rsp_stall_i,
`endif
    obi_mem_responder_if.slave bus,
    output logic [1:0]         pnd_cnt_o
);
    localparam int         AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [2:0] LAT_AGE   = 3'(LATENCY);
    // An entry of this age pops now, so rvalid lands exactly LATENCY cycles after grant.
    localparam logic [2:0] READY_AGE = 3'(LATENCY - 1);
    localparam logic [1:0] MAX_CNT   = 2'(MAX_PND);

    logic [31:0]   r_mem       [MEM_WORDS];
    logic [31:0]   r_fifo_data [MAX_PND];
    logic [2:0]    r_fifo_age  [MAX_PND];
    logic [1:0]    r_fifo_cnt;
    logic [1:0]    r_pnd_cnt;
    logic          r_rvalid;
    logic [31:0]   r_rdata;

    logic          w_gnt_stall;
    logic          w_rsp_stall;
    logic [AW-1:0] w_idx;
    logic          w_gnt;
    logic [31:0]   w_rsp_data;
    logic          w_head_ready;
    logic          w_bypass;
    logic          w_pop;
    logic          w_pop_fifo;
    logic          w_push_fifo;
    logic [1:0]    w_push_idx;
    logic [31:0]   w_pop_data;
    logic [31:0]   w_nxt_data  [MAX_PND];
    logic [2:0]    w_nxt_age   [MAX_PND];
    logic [1:0]    w_nxt_cnt;

`ifdef OBI_RESP_STALL_EN
    assign w_gnt_stall = gnt_stall_i;
    assign w_rsp_stall = rsp_stall_i;
`else
    assign w_gnt_stall = 1'b0;
    assign w_rsp_stall = 1'b0;
`endif

    function automatic logic [2:0] sat_inc(input logic [2:0] a);
        return (a >= LAT_AGE) ? a : a + 3'd1;
    endfunction

    // Upper address bits alias onto the array.
    assign w_idx      = bus.addr[AW+1:2];

    // A slot freed by this cycle's response is only reusable next cycle.
    assign w_gnt      = bus.req & (r_pnd_cnt < MAX_CNT) & ~w_gnt_stall;
    assign bus.gnt    = w_gnt;

    // Read data is captured at grant time; writes answer with zero.
    assign w_rsp_data = bus.we ? 32'h0 : r_mem[w_idx];

    assign w_head_ready = (r_fifo_cnt != 2'd0) && (r_fifo_age[0] >= READY_AGE);
    // With LATENCY==1 a grant into an empty queue goes straight to the output.
    assign w_bypass     = (LATENCY == 1) && (r_fifo_cnt == 2'd0) && w_gnt;
    assign w_pop        = (w_head_ready | w_bypass) & ~w_rsp_stall;
    assign w_pop_fifo   = w_pop & (r_fifo_cnt != 2'd0);
    assign w_push_fifo  = w_gnt & ~(w_pop & (r_fifo_cnt == 2'd0));
    assign w_push_idx   = 2'(r_fifo_cnt - {1'b0, w_pop_fifo});
    assign w_pop_data   = (r_fifo_cnt != 2'd0) ? r_fifo_data[0] : w_rsp_data;
    assign w_nxt_cnt    = 2'(r_fifo_cnt + {1'b0, w_push_fifo} - {1'b0, w_pop_fifo});

    // Next FIFO contents: shift on pop, age every entry, append on push.
    always_comb begin
        for (int i = 0; i < MAX_PND; i++) begin
            w_nxt_data[i] = r_fifo_data[i];
            w_nxt_age[i]  = r_fifo_age[i];
        end
        for (int i = 0; i < MAX_PND; i++) begin
            if (w_pop_fifo) begin
                if (i + 1 < MAX_PND) begin
                    w_nxt_data[i] = r_fifo_data[(i + 1 < MAX_PND) ? i + 1 : i];
                    w_nxt_age[i]  = sat_inc(r_fifo_age[(i + 1 < MAX_PND) ? i + 1 : i]);
                end
            end else begin
                w_nxt_age[i] = sat_inc(r_fifo_age[i]);
            end
        end
        for (int i = 0; i < MAX_PND; i++) begin
            if (w_push_fifo && (2'(i) == w_push_idx)) begin
                w_nxt_data[i] = w_rsp_data;
                w_nxt_age[i]  = 3'd1;
            end
        end
    end

    // Memory array: cleared on reset, byte-enabled write on a granted write.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                r_mem[i] <= 32'h0;
            end
        end else if (w_gnt && bus.we) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= bus.wdata[8*b +: 8];
                end
            end
        end
    end

    // Response FIFO registers; reset drops every queued response.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_fifo_cnt <= 2'd0;
            for (int i = 0; i < MAX_PND; i++) begin
                r_fifo_data[i] <= 32'h0;
                r_fifo_age[i]  <= 3'd0;
            end
        end else begin
            r_fifo_cnt <= w_nxt_cnt;
            for (int i = 0; i < MAX_PND; i++) begin
                r_fifo_data[i] <= w_nxt_data[i];
                r_fifo_age[i]  <= w_nxt_age[i];
            end
        end
    end

    // Registered response and outstanding count; a transaction stays counted through its rvalid cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rvalid  <= 1'b0;
            r_rdata   <= 32'h0;
            r_pnd_cnt <= 2'd0;
        end else begin
            r_rvalid  <= w_pop;
            if (w_pop) begin
                r_rdata <= w_pop_data;
            end
            r_pnd_cnt <= 2'(r_pnd_cnt + {1'b0, w_gnt} - {1'b0, r_rvalid});
        end
    end

    assign bus.rvalid = r_rvalid;
    assign bus.rdata  = r_rdata;
    assign pnd_cnt_o  = r_pnd_cnt;

    a_no_gnt_when_full: assert property (@(posedge clock) disable iff (reset)
        (r_pnd_cnt == MAX_CNT) |-> !w_gnt);
    a_no_orphan_rvalid: assert property (@(posedge clock) disable iff (reset)
        r_rvalid |-> (r_pnd_cnt != 2'd0));
    a_pnd_bounded: assert property (@(posedge clock) disable iff (reset)
        r_pnd_cnt <= MAX_CNT);
endmodule

// File: tb/tb_obi_mem_responder.sv
// Bench for obi_mem_responder: directed scenarios plus a random stream, all
// compared against a transaction-level model (array + due-time queue).
module tb_obi_mem_responder;
    localparam int MEM_WORDS = 256;
    localparam int MAX_PND   = 2;
    localparam int LATENCY   = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       gnt_stall = 1'b0;
    logic       rsp_stall = 1'b0;
    logic [1:0] pnd_cnt;

    obi_mem_responder_if bus();

    obi_mem_responder #(
        .MEM_WORDS(MEM_WORDS),
        .MAX_PND  (MAX_PND),
        .LATENCY  (LATENCY)
    ) dut (
        .clock      (clock),
        .reset      (reset),
`ifdef OBI_RESP_STALL_EN
        .gnt_stall_i(gnt_stall),
        .rsp_stall_i(rsp_stall),
`endif
        .bus        (bus),
        .pnd_cnt_o  (pnd_cnt)
    );

    // Clock
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: memory image, queue of pending responses with due cycle
    logic [31:0] m_mem [MEM_WORDS];
    logic [31:0] exp_q[$];
    int          due_q[$];
    int          m_pnd;
    logic        m_rv;
    logic [31:0] m_rd;
    int          cyc;

    // Per-cycle observation and expectation
    int          obs_cyc;
    logic        obs_gnt, obs_rv;
    logic [31:0] obs_rd;
    logic [1:0]  obs_pnd;
    logic        exp_gnt, exp_rv;
    logic [31:0] exp_rd;
    int          exp_pnd;
    logic [31:0] rv_data_q[$];
    int          rv_cyc_q[$];

    task automatic model_reset();
        exp_q.delete();
        due_q.delete();
        m_pnd = 0;
        m_rv  = 1'b0;
        m_rd  = 32'h0;
        for (int i = 0; i < MEM_WORDS; i++) m_mem[i] = 32'h0;
    endtask

    // Advance one cycle: sample DUT mid-cycle, then step the model at the edge.
    task automatic tick();
        logic        grant, stall_r, we;
        logic [31:0] addr, wd;
        logic [3:0]  be;
        int          word;
        @(negedge clock);
        obs_cyc = cyc;
        obs_gnt = bus.gnt;
        obs_rv  = bus.rvalid;
        obs_rd  = bus.rdata;
        obs_pnd = pnd_cnt;
        exp_gnt = bus.req && (m_pnd < MAX_PND) && !gnt_stall;
        exp_rv  = m_rv;
        exp_rd  = m_rd;
        exp_pnd = m_pnd;
        if (obs_rv === 1'b1) begin
            rv_data_q.push_back(obs_rd);
            rv_cyc_q.push_back(obs_cyc);
        end
        grant   = exp_gnt;
        stall_r = rsp_stall;
        we      = bus.we;
        addr    = bus.addr;
        be      = bus.be;
        wd      = bus.wdata;
        @(posedge clock);
        cyc   = cyc + 1;
        m_pnd = m_pnd + int'(grant) - int'(m_rv);
        if (grant) begin
            word = int'((addr >> 2) % MEM_WORDS);
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) m_mem[word][8*b +: 8] = wd[8*b +: 8];
                exp_q.push_back(32'h0);
            end else begin
                exp_q.push_back(m_mem[word]);
            end
            due_q.push_back(obs_cyc + LATENCY);
        end
        if (exp_q.size() > 0 && due_q[0] <= cyc && !stall_r) begin
            m_rv = 1'b1;
            m_rd = exp_q.pop_front();
            void'(due_q.pop_front());
        end else begin
            m_rv = 1'b0;
        end
        #1;
    endtask

    // Driver: present a request until granted (bounded); gcyc=-1 on timeout.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wd, output int gcyc);
        bus.req = 1'b1; bus.we = we; bus.addr = addr; bus.be = be; bus.wdata = wd;
        gcyc = -1;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (obs_gnt === 1'b1) begin
                gcyc = obs_cyc;
                break;
            end
        end
        bus.req = 1'b0;
    endtask

    task automatic wait_rv(input int n);
        for (int k = 0; k < 60; k++) begin
            if (rv_data_q.size() >= n) break;
            tick();
        end
    endtask

    task automatic drain();
        bus.req = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (m_pnd == 0) break;
            tick();
        end
        rv_data_q.delete();
        rv_cyc_q.delete();
    endtask

    task automatic apply_reset();
        bus.req = 1'b0;
        reset   = 1'b1;
        model_reset();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        rv_data_q.delete();
        rv_cyc_q.delete();
    endtask

    task automatic test_reset();
        int gr;
        apply_reset();
        tick();
        checks++;
        if (obs_gnt !== 1'b0 || obs_rv !== 1'b0 || obs_rd !== 32'h0 || obs_pnd !== 2'd0) begin
            errors++;
            $display("FAIL reset_outputs: gnt=%b rvalid=%b rdata=%h pnd=%0d, required 0/0/0/0",
                     obs_gnt, obs_rv, obs_rd, obs_pnd);
        end
        issue(1'b0, {$urandom} & 32'h0000_03FC, 4'h0, 32'h0, gr);
        wait_rv(1);
        checks++;
        if (rv_data_q.size() != 1 || rv_data_q[0] !== 32'h0) begin
            errors++;
            $display("FAIL reset_mem_zero: responses=%0d, required one response of 0",
                     rv_data_q.size());
        end
        drain();
    endtask

    task automatic test_write_read();
        int gw, gr;
        issue(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, gw);
        issue(1'b0, 32'h10, 4'h0, 32'h0, gr);
        wait_rv(2);
        checks++;
        if (gw < 0 || gr < 0 || rv_data_q.size() != 2) begin
            errors++;
            $display("FAIL wr_rd_count: gw=%0d gr=%0d responses=%0d, required two grants and 2 responses",
                     gw, gr, rv_data_q.size());
        end else begin
            checks++;
            if (rv_data_q[0] !== 32'h0) begin
                errors++;
                $display("FAIL wr_rsp_data: got %h required 00000000", rv_data_q[0]);
            end
            checks++;
            if (rv_data_q[1] !== 32'hDEADBEEF) begin
                errors++;
                $display("FAIL rd_data: got %h required deadbeef", rv_data_q[1]);
            end
            checks++;
            if (rv_cyc_q[1] - gr != LATENCY) begin
                errors++;
                $display("FAIL rd_latency: got %0d required %0d", rv_cyc_q[1] - gr, LATENCY);
            end
        end
        drain();
    endtask

    task automatic test_byte_enable();
        int gw, gr;
        issue(1'b1, 32'h10, 4'b0010, 32'h0000AB00, gw);
        issue(1'b0, 32'h10, 4'h0, 32'h0, gr);
        wait_rv(2);
        checks++;
        if (rv_data_q.size() != 2 || rv_data_q[1] !== 32'hDEADABEF) begin
            errors++;
            $display("FAIL byte_enable: responses=%0d last=%h required deadabef",
                     rv_data_q.size(), (rv_data_q.size() > 0) ? rv_data_q[rv_data_q.size()-1] : 32'h0);
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic [4:0] exp_pat;
        logic [4:0] got_pat;
        logic [1:0] pnd_c2;
        exp_pat = 5'b10011;
        bus.req = 1'b1; bus.we = 1'b0; bus.addr = 32'h20; bus.be = 4'h0; bus.wdata = 32'h0;
        for (int i = 0; i < 5; i++) begin
            tick();
            got_pat[i] = obs_gnt;
            if (i == 2) pnd_c2 = obs_pnd;
            checks++;
            if (obs_gnt !== exp_gnt || obs_pnd !== 2'(exp_pnd)) begin
                errors++;
                $display("FAIL bp_cycle%0d: gnt=%b pnd=%0d required gnt=%b pnd=%0d",
                         i, obs_gnt, obs_pnd, exp_gnt, exp_pnd);
            end
        end
        bus.req = 1'b0;
        checks++;
        if (got_pat !== exp_pat) begin
            errors++;
            $display("FAIL bp_gnt_pattern: got %b required %b", got_pat, exp_pat);
        end
        checks++;
        if (pnd_c2 !== 2'd2) begin
            errors++;
            $display("FAIL bp_pnd_full: got %0d required 2", pnd_c2);
        end
        checks++;
        if (rv_cyc_q.size() < 1 || rv_cyc_q[0] - (cyc - 5) != 3) begin
            errors++;
            $display("FAIL bp_first_rvalid: rvalids=%0d required first at relative cycle 3",
                     rv_cyc_q.size());
        end
        drain();
    endtask

    task automatic test_aliasing();
        int gw, gr1, gr2;
        logic [31:0] hi;
        hi = {$urandom} & 32'hFFFF_FC00;
        issue(1'b1, 32'h004, 4'hF, 32'h00000055, gw);
        issue(1'b0, 32'h404, 4'h0, 32'h0, gr1);
        issue(1'b0, hi | 32'h4, 4'h0, 32'h0, gr2);
        wait_rv(3);
        checks++;
        if (rv_data_q.size() != 3 || rv_data_q[1] !== 32'h00000055 || rv_data_q[2] !== 32'h00000055) begin
            errors++;
            $display("FAIL aliasing: responses=%0d rd1=%h rd2=%h required 00000055 twice",
                     rv_data_q.size(), (rv_data_q.size() > 1) ? rv_data_q[1] : 32'h0,
                     (rv_data_q.size() > 2) ? rv_data_q[2] : 32'h0);
        end
        drain();
    endtask

    task automatic test_reset_pending();
        int gr;
        bus.req = 1'b1; bus.we = 1'b0; bus.addr = 32'h10;
        tick();
        tick();
        bus.req = 1'b0;
        #1;
        checks++;
        if (pnd_cnt !== 2'd2) begin
            errors++;
            $display("FAIL rst_pend_setup: pnd=%0d required 2", pnd_cnt);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (bus.rvalid !== 1'b0 || pnd_cnt !== 2'd0 || bus.gnt !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: rvalid=%b pnd=%0d gnt=%b required 0/0/0",
                     bus.rvalid, pnd_cnt, bus.gnt);
        end
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (obs_rv !== 1'b0 || obs_pnd !== 2'd0) begin
                errors++;
                $display("FAIL rst_drop_cycle%0d: rvalid=%b pnd=%0d required 0/0", i, obs_rv, obs_pnd);
            end
        end
        issue(1'b0, 32'h10, 4'h0, 32'h0, gr);
        wait_rv(1);
        checks++;
        if (rv_data_q.size() != 1 || rv_data_q[0] !== 32'h0) begin
            errors++;
            $display("FAIL rst_mem_clear: responses=%0d required one response of 0", rv_data_q.size());
        end
        drain();
    endtask

`ifdef OBI_RESP_STALL_EN
    task automatic test_stall();
        int gr, rel;
        gnt_stall = 1'b1;
        bus.req = 1'b1; bus.we = 1'b0; bus.addr = 32'h20;
        tick();
        checks++;
        if (obs_gnt !== 1'b0) begin
            errors++;
            $display("FAIL gnt_stall: gnt=%b required 0", obs_gnt);
        end
        gnt_stall = 1'b0;
        rsp_stall = 1'b1;
        issue(1'b0, 32'h20, 4'h0, 32'h0, gr);
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (obs_rv !== 1'b0 || obs_pnd !== 2'd1) begin
                errors++;
                $display("FAIL rsp_stall_cycle%0d: rvalid=%b pnd=%0d required 0/1", i, obs_rv, obs_pnd);
            end
        end
        rsp_stall = 1'b0;
        rel = cyc;
        wait_rv(1);
        checks++;
        if (rv_cyc_q.size() != 1 || rv_cyc_q[0] != rel + 1) begin
            errors++;
            $display("FAIL rsp_stall_release: rvalids=%0d cycle=%0d required 1 at %0d",
                     rv_cyc_q.size(), (rv_cyc_q.size() > 0) ? rv_cyc_q[0] : -1, rel + 1);
        end
        drain();
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bus.req   = ($urandom_range(0, 9) < 7);
            bus.we    = $urandom_range(0, 1) == 1;
            bus.addr  = ({$urandom} & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2)
                        | 32'($urandom_range(0, 3));
            bus.be    = 4'($urandom_range(0, 15));
            bus.wdata = $urandom;
`ifdef OBI_RESP_STALL_EN
            gnt_stall = ($urandom_range(0, 9) == 0);
            rsp_stall = ($urandom_range(0, 9) == 0);
`endif
            tick();
            checks++;
            if (obs_gnt !== exp_gnt || obs_rv !== exp_rv || obs_rd !== exp_rd || obs_pnd !== 2'(exp_pnd)) begin
                errors++;
                $display("FAIL rand_cycle%0d: gnt=%b rv=%b rd=%h pnd=%0d required gnt=%b rv=%b rd=%h pnd=%0d",
                         i, obs_gnt, obs_rv, obs_rd, obs_pnd, exp_gnt, exp_rv, exp_rd, exp_pnd);
            end
        end
        gnt_stall = 1'b0;
        rsp_stall = 1'b0;
        drain();
        #1;
        checks++;
        if (pnd_cnt !== 2'd0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL rand_drain: pnd=%0d model_pending=%0d required 0/0", pnd_cnt, exp_q.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.req = 1'b0; bus.we = 1'b0; bus.addr = 32'h0; bus.be = 4'h0; bus.wdata = 32'h0;
        cyc = 0;
        model_reset();
        test_reset();
        test_write_read();
        test_byte_enable();
        test_backpressure();
        test_aliasing();
        test_reset_pending();
`ifdef OBI_RESP_STALL_EN
        test_stall();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
